// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: registers WB control/results and services loads/stores to an internal word RAM.
// Latency: 1 cycle for non-memory ops; WAIT_CYCLES+1 cycles from acceptance to DONE outputs for memory ops.
// Backpressure: stall is raised combinationally when a request is accepted and held through BUSY; upstream holds its inputs.
module mem_access_stage #(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        jumpI,
  input  logic        memtoRegI,
  input  logic        regWriteI,
  input  logic        memReadI,
  input  logic        memWriteI,
  input  logic [31:0] aluResultI,
  input  logic [31:0] writeDataI,
  input  logic [4:0]  writeRegistrerI,
  output logic        jumpO,
  output logic        memtoRegO,
  output logic        regWriteO,
  output logic [31:0] readDataO,
  output logic [31:0] aluResultO,
  output logic [4:0]  writeRegistrerO,
  output logic        stall,
  output logic        misalignO
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(WAIT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state, next_state;
  logic [CW-1:0]   cnt;
  logic            stall_c;

  // Request captured at acceptance; the stage owns it until DONE.
  logic            cap_jump, cap_mtr, cap_rw, cap_rd, cap_wr;
  logic [31:0]     cap_alu, cap_wd, cap_rdata;
  logic [4:0]      cap_reg;

  logic [31:0]     mem [DEPTH];

  logic            mem_req, aligned, last_wait;
  logic [AW-1:0]   cap_idx;

  assign mem_req   = memReadI | memWriteI;
  assign aligned   = (aluResultI[1:0] == 2'b00);
  assign last_wait = (cnt == CW'(1));
  // Word index ignores upper address bits, so addresses wrap modulo DEPTH words.
  assign cap_idx   = cap_alu[AW+1:2];

  // Stall is forced low while in reset so upstream is never frozen by a stale request.
  assign stall = stall_c & rst_n;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state and stall decode.
  always_comb begin
    next_state = state;
    stall_c    = 1'b0;
    case (state)
      IDLE: begin
        if (mem_req && aligned) begin
          next_state = BUSY;
          stall_c    = 1'b1;
        end
      end
      BUSY: begin
        stall_c = 1'b1;
        if (last_wait) next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath: input capture, wait counter, load data and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt             <= '0;
      cap_jump        <= 1'b0;
      cap_mtr         <= 1'b0;
      cap_rw          <= 1'b0;
      cap_rd          <= 1'b0;
      cap_wr          <= 1'b0;
      cap_alu         <= '0;
      cap_wd          <= '0;
      cap_reg         <= '0;
      cap_rdata       <= '0;
      jumpO           <= 1'b0;
      memtoRegO       <= 1'b0;
      regWriteO       <= 1'b0;
      readDataO       <= '0;
      aluResultO      <= '0;
      writeRegistrerO <= '0;
      misalignO       <= 1'b0;
    end else begin
      misalignO <= 1'b0;
      readDataO <= '0;
      case (state)
        IDLE: begin
          aluResultO      <= aluResultI;
          writeRegistrerO <= writeRegistrerI;
          if (mem_req && aligned) begin
            cap_jump  <= jumpI;
            cap_mtr   <= memtoRegI;
            cap_rw    <= regWriteI;
            cap_rd    <= memReadI;
            cap_wr    <= memWriteI;
            cap_alu   <= aluResultI;
            cap_wd    <= writeDataI;
            cap_reg   <= writeRegistrerI;
            cnt       <= CW'(WAIT_CYCLES);
            jumpO     <= 1'b0;
            memtoRegO <= 1'b0;
            regWriteO <= 1'b0;
          end else begin
            // Plain pass-through; a misaligned request is dropped and its register write squashed.
            jumpO     <= jumpI;
            memtoRegO <= memtoRegI;
            regWriteO <= regWriteI & ~mem_req;
            misalignO <= mem_req;
          end
        end
        BUSY: begin
          cnt       <= cnt - CW'(1);
          jumpO     <= 1'b0;
          memtoRegO <= 1'b0;
          regWriteO <= 1'b0;
          if (last_wait) cap_rdata <= (cap_rd && !cap_wr) ? mem[cap_idx] : 32'h0;
        end
        DONE: begin
          jumpO           <= cap_jump;
          memtoRegO       <= cap_mtr;
          regWriteO       <= cap_rw;
          aluResultO      <= cap_alu;
          writeRegistrerO <= cap_reg;
          readDataO       <= cap_rdata;
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

  // RAM write on the final wait edge; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (rst_n && state == BUSY && last_wait && cap_wr) mem[cap_idx] <= cap_wd;
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: pass-through, load/store latency, misalign, wrap, reset abort.
// Inputs are driven on the falling edge and outputs sampled 1ns later, well away from the rising edge.
// Memory ops hold inputs while stall is high, mirroring an upstream stage.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        jumpI, memtoRegI, regWriteI, memReadI, memWriteI;
  logic [31:0] aluResultI, writeDataI;
  logic [4:0]  writeRegistrerI;
  logic        jumpO, memtoRegO, regWriteO, stall, misalignO;
  logic [31:0] readDataO, aluResultO;
  logic [4:0]  writeRegistrerO;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.DEPTH(64), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .jumpI(jumpI), .memtoRegI(memtoRegI), .regWriteI(regWriteI),
    .memReadI(memReadI), .memWriteI(memWriteI),
    .aluResultI(aluResultI), .writeDataI(writeDataI), .writeRegistrerI(writeRegistrerI),
    .jumpO(jumpO), .memtoRegO(memtoRegO), .regWriteO(regWriteO),
    .readDataO(readDataO), .aluResultO(aluResultO), .writeRegistrerO(writeRegistrerO),
    .stall(stall), .misalignO(misalignO)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic j, input logic mtr, input logic rw, input logic rd,
                       input logic wr, input logic [31:0] alu, input logic [31:0] wd,
                       input logic [4:0] rg);
    jumpI = j; memtoRegI = mtr; regWriteI = rw; memReadI = rd; memWriteI = wr;
    aluResultI = alu; writeDataI = wd; writeRegistrerI = rg;
  endtask

  task automatic drive_nop();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
  endtask

  // One aligned memory op: counts stall cycles, checks the bubble and the DONE outputs.
  task automatic mem_op(input string tag, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [4:0] rg, input logic [31:0] exp_rdata);
    int n;
    logic ld;
    ld = rd & ~wr;
    @(negedge clk);
    drive(1'b0, ld, ld, rd, wr, addr, wd, rg);
    #1;
    n = 0;
    while (stall && n < 20) begin
      n++;
      if (n == 2) check({tag, "_bubble_regwrite"}, {31'h0, regWriteO}, 32'h0);
      @(negedge clk);
      #1;
    end
    check({tag, "_stall_cycles"}, n, 3);
    drive_nop();
    @(negedge clk);
    #1;
    check({tag, "_rdata"}, readDataO, exp_rdata);
    check({tag, "_wreg"}, {27'h0, writeRegistrerO}, {27'h0, rg});
    check({tag, "_memtoreg"}, {31'h0, memtoRegO}, {31'h0, ld});
    check({tag, "_regwrite"}, {31'h0, regWriteO}, {31'h0, ld});
    check({tag, "_alu"}, aluResultO, addr);
  endtask

  initial begin
    rst_n = 1'b0;
    drive_nop();
    #1;
    check("rst_stall", {31'h0, stall}, 32'h0);
    check("rst_alu", aluResultO, 32'h0);
    check("rst_regwrite", {31'h0, regWriteO}, 32'h0);
    check("rst_misalign", {31'h0, misalignO}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Non-memory pass-through
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h1234, 32'h0, 5'd5);
    #1;
    check("nop_stall", {31'h0, stall}, 32'h0);
    @(negedge clk);
    #1;
    check("nop_alu", aluResultO, 32'h1234);
    check("nop_regwrite", {31'h0, regWriteO}, 32'h1);
    check("nop_wreg", {27'h0, writeRegistrerO}, 32'd5);
    check("nop_rdata", readDataO, 32'h0);

    // Store then load
    mem_op("st10", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 5'd0, 32'h0);
    mem_op("ld10", 1'b1, 1'b0, 32'h10, 32'h0, 5'd8, 32'hDEADBEEF);

    // Misaligned load
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h13, 32'h0, 5'd9);
    #1;
    check("mis_stall", {31'h0, stall}, 32'h0);
    @(negedge clk);
    drive_nop();
    #1;
    check("mis_pulse", {31'h0, misalignO}, 32'h1);
    check("mis_regwrite", {31'h0, regWriteO}, 32'h0);
    check("mis_rdata", readDataO, 32'h0);
    check("mis_stall2", {31'h0, stall}, 32'h0);
    @(negedge clk);
    #1;
    check("mis_pulse_end", {31'h0, misalignO}, 32'h0);

    // Address wrap
    mem_op("st100", 1'b0, 1'b1, 32'h100, 32'h55, 5'd0, 32'h0);
    mem_op("ld0", 1'b1, 1'b0, 32'h0, 32'h0, 5'd3, 32'h55);

    // Reset aborts a pending store
    mem_op("st20a", 1'b0, 1'b1, 32'h20, 32'hAA, 5'd0, 32'h0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h20, 32'hBB, 5'd0);
    #1;
    check("abort_stall_pre", {31'h0, stall}, 32'h1);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_stall", {31'h0, stall}, 32'h0);
    check("abort_alu", aluResultO, 32'h0);
    check("abort_rdata", readDataO, 32'h0);
    check("abort_wreg", {27'h0, writeRegistrerO}, 32'h0);
    @(negedge clk);
    drive_nop();
    @(negedge clk);
    rst_n = 1'b1;
    mem_op("ld20", 1'b1, 1'b0, 32'h20, 32'h0, 5'd4, 32'hAA);

    // Read and write together: write wins, no load data
    mem_op("rw8", 1'b1, 1'b1, 32'h8, 32'h77, 5'd0, 32'h0);
    mem_op("ld8", 1'b1, 1'b0, 32'h8, 32'h0, 5'd6, 32'h77);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 Parameter: DEPTH, 64, number of 32-bit data-memory words (power of two).
REQ-002 Parameter: WAIT_CYCLES, 2, extra wait states per memory access (>=1).
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 jumpI, memtoRegI, regWriteI  in  1 each  WB control from EX/MEM register.
REQ-006 memReadI, memWriteI  in  1 each  load/store request.
REQ-007 aluResultI  in  32  byte address for loads/stores, pass-through result otherwise.
REQ-008 writeDataI  in  32  store data.
REQ-009 writeRegistrerI  in  5  destination register number.
REQ-010 jumpO, memtoRegO, regWriteO  out  1 each  registered WB control, feeds MEM/WB register.
REQ-011 readDataO  out  32  registered load data.
REQ-012 aluResultO  out  32  registered ALU result.
REQ-013 writeRegistrerO  out  5  registered destination register.
REQ-014 stall  out  1  high while a memory access is in progress; upstream holds its inputs.
REQ-015 misalignO  out  1  one-cycle pulse on a discarded misaligned access.

Function
REQ-016 Internal word RAM of DEPTH entries, index = aluResultI[log2(DEPTH)+1:2]; upper address bits ignored (wrap-around).
REQ-017 FSM states: IDLE, BUSY, DONE.
REQ-018 IDLE, memReadI=memWriteI=0: all outputs register inputs next edge (1-cycle latency), readDataO=0, stall=0, stay IDLE.
REQ-019 IDLE, memReadI or memWriteI=1, aluResultI[1:0]=00: capture all inputs, counter=WAIT_CYCLES, stall=1 (combinational, same cycle), go BUSY.
REQ-020 IDLE, memory request with aluResultI[1:0]!=00: no RAM access, outputs registered with regWriteO=0, readDataO=0, misalignO=1 for one cycle, stay IDLE.
REQ-021 BUSY: counter decrements each edge; stall=1; inputs ignored; regWriteO=0, jumpO=0 (bubble to WB).
REQ-022 BUSY with counter=1: perform access this edge (write RAM or read word into readDataO), go DONE.
REQ-023 DONE: outputs present captured controls, aluResult, writeRegistrer and readData for exactly one cycle; stall=0; go IDLE; upstream advances this cycle.
REQ-024 Memory-op latency: request accepted at edge N yields DONE outputs after edge N+WAIT_CYCLES+1.
REQ-025 memReadI and memWriteI both high: write performed, readDataO=0.
REQ-026 Store: regWriteO as captured (normally 0); readDataO=0.
REQ-027 RAM contents are not reset and are undefined until written.

Reset
REQ-028 rst_n low: FSM=IDLE, counter=0, stall=0, misalignO=0, all data/control outputs 0, independent of clk.
REQ-029 Reset during BUSY: pending access aborted; pending store not written; RAM otherwise unchanged.
REQ-030 First accepted request is the one presented at the first rising edge with rst_n high.

Verification
REQ-031 Reset then non-memory op aluResultI=0x1234, regWriteI=1, writeRegistrerI=5 -> next edge aluResultO=0x1234, regWriteO=1, writeRegistrerO=5, stall=0.
REQ-032 Store 0xDEADBEEF to 0x10, then load 0x10 into reg 8 -> each: stall high 3 cycles (WAIT_CYCLES=2); load DONE readDataO=0xDEADBEEF, writeRegistrerO=8, memtoRegO=1.
REQ-033 Load from 0x13 -> misalignO=1 one cycle, regWriteO=0, readDataO=0, stall never asserted.
REQ-034 Store 0x55 to 0x100 (DEPTH=64), load 0x0 -> readDataO=0x55 (wrap).
REQ-035 Store 0xAA to 0x20 then store 0xBB to 0x20, rst_n low during 2nd BUSY; load 0x20 -> readDataO=0xAA, outputs 0 during reset.
REQ-036 memReadI=memWriteI=1, data 0x77 to 0x8 -> readDataO=0 at DONE; subsequent load 0x8 returns 0x77.
